// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and the request bundle for the memory port arbiter.
// Owner and state codes are 2 bits; owner code 3 means the port is free.
package jala_arb_pkg;

   localparam int ARB_AW = 16;
   localparam int ARB_DW = 16;

   typedef enum logic [1:0] {
      OWN_F    = 2'd0,
      OWN_M    = 2'd1,
      OWN_R    = 2'd2,
      OWN_NONE = 2'd3
   } owner_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_e;

   typedef struct packed {
      logic              we;
      logic [ARB_AW-1:0] addr;
      logic [ARB_DW-1:0] wdata;
   } req_t;

   // Rotation order F -> M -> R -> F.
   function automatic owner_e next_owner(input owner_e o);
      case (o)
         OWN_F:   return OWN_M;
         OWN_M:   return OWN_R;
         default: return OWN_F;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select over {R,M,F} requests; zero latency, never stalls.
// ARB_ROUND_ROBIN_EN selects round-robin from i_ptr; otherwise fixed F > M > R.
module arb_pick
   import jala_arb_pkg::*;
(
   input  logic [2:0] i_req,
   input  owner_e     i_ptr,
   output owner_e     o_win,
   output logic       o_vld
);

   assign o_vld = |i_req;

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      o_win = OWN_NONE;
      case (i_ptr)
         OWN_M: begin
            if (i_req[1])      o_win = OWN_M;
            else if (i_req[2]) o_win = OWN_R;
            else if (i_req[0]) o_win = OWN_F;
         end
         OWN_R: begin
            if (i_req[2])      o_win = OWN_R;
            else if (i_req[0]) o_win = OWN_F;
            else if (i_req[1]) o_win = OWN_M;
         end
         default: begin
            if (i_req[0])      o_win = OWN_F;
            else if (i_req[1]) o_win = OWN_M;
            else if (i_req[2]) o_win = OWN_R;
         end
      endcase
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      o_win = OWN_NONE;
      if (i_req[0])      o_win = OWN_F;
      else if (i_req[1]) o_win = OWN_M;
      else if (i_req[2]) o_win = OWN_R;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among fetch, main stack and return stack; LAT+3 cycles per access.
// Busy stalls the control FSM; ARB_ROUND_ROBIN_EN switches fixed priority to round-robin.
module mem_port_arbiter
   import jala_arb_pkg::*;
#(
   parameter int AW  = ARB_AW,
   parameter int DW  = ARB_DW,
   parameter int LAT = 1
)(
   input  logic          CLK,
   input  logic          CtrlRst,
   input  logic          FReq,
   input  logic          MReq,
   input  logic          RReq,
   input  logic          FWe,
   input  logic          MWe,
   input  logic          RWe,
   input  logic [AW-1:0] FAddr,
   input  logic [AW-1:0] MAddr,
   input  logic [AW-1:0] RAddr,
   input  logic [DW-1:0] FWData,
   input  logic [DW-1:0] MWData,
   input  logic [DW-1:0] RWData,
   output logic          FAck,
   output logic          MAck,
   output logic          RAck,
   output logic [DW-1:0] RData,
   output logic          MemEn,
   output logic          MemWe,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   input  logic [DW-1:0] MemRData,
   output logic          Busy,
   output logic [1:0]    Owner
);

   localparam logic [2:0] LAT_CNT = 3'(LAT);

   state_e        r_state;
   state_e        w_state_nxt;
   owner_e        r_owner;
   owner_e        r_ptr;
   req_t          r_req;
   logic [2:0]    r_cnt;
   logic [DW-1:0] r_rdata;

   owner_e        w_win;
   logic          w_win_vld;
   req_t          w_sel;
   logic          w_wait_last;

   arb_pick u_pick (
      .i_req (RReq ? {1'b1, MReq, FReq} : {1'b0, MReq, FReq}),
      .i_ptr (r_ptr),
      .o_win (w_win),
      .o_vld (w_win_vld)
   );

   always_comb begin
      w_sel.we    = FWe;
      w_sel.addr  = FAddr;
      w_sel.wdata = FWData;
      case (w_win)
         OWN_M: begin
            w_sel.we    = MWe;
            w_sel.addr  = MAddr;
            w_sel.wdata = MWData;
         end
         OWN_R: begin
            w_sel.we    = RWe;
            w_sel.addr  = RAddr;
            w_sel.wdata = RWData;
         end
         default: ;
      endcase
   end

   assign w_wait_last = (r_cnt == LAT_CNT);

   always_ff @(posedge CLK) begin
      if (CtrlRst) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      MemEn       = 1'b0;
      MemWe       = 1'b0;
      FAck        = 1'b0;
      MAck        = 1'b0;
      RAck        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_win_vld) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            MemEn       = 1'b1;
            MemWe       = r_req.we;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_wait_last) w_state_nxt = S_ACK;
         end
         S_ACK: begin
            FAck        = (r_owner == OWN_F);
            MAck        = (r_owner == OWN_M);
            RAck        = (r_owner == OWN_R);
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operands are frozen at grant; requester changes after that are ignored.
   always_ff @(posedge CLK) begin
      if (CtrlRst) begin
         r_owner <= OWN_NONE;
         r_ptr   <= OWN_F;
         r_req   <= '0;
         r_cnt   <= 3'd0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_owner <= w_win;
                  r_req   <= w_sel;
                  r_ptr   <= next_owner(w_win);
               end
            end
            S_ISSUE: r_cnt <= 3'd1;
            S_WAIT: begin
               r_cnt <= r_cnt + 3'd1;
               if (w_wait_last && !r_req.we) r_rdata <= MemRData;
            end
            S_ACK:   r_owner <= OWN_NONE;
            default: ;
         endcase
      end
   end

   assign MemAddr  = r_req.addr;
   assign MemWData = r_req.wdata;
   assign RData    = r_rdata;
   assign Busy     = (r_state != S_IDLE);
   assign Owner    = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (LAT=1 and LAT=3) against a transaction-level model plus directed checks.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;

   logic        freq [2], mreq [2], rreq [2];
   logic        fwe  [2], mwe  [2], rwe  [2];
   logic [15:0] faddr[2], maddr[2], raddr[2];
   logic [15:0] fwd  [2], mwd  [2], rwd  [2];
   logic        fack [2], mack [2], rack [2];
   logic [15:0] rdata[2];
   logic        memen[2], memwe[2];
   logic [15:0] memaddr[2], memwdata[2], memrdata[2];
   logic        busy [2];
   logic [1:0]  owner[2];

   int n_cmp = 0;
   int n_bad = 0;
   logic armed = 1'b0;

   mem_port_arbiter #(.AW(16), .DW(16), .LAT(1)) dut1 (
      .CLK(clk), .CtrlRst(rst),
      .FReq(freq[0]), .MReq(mreq[0]), .RReq(rreq[0]),
      .FWe(fwe[0]), .MWe(mwe[0]), .RWe(rwe[0]),
      .FAddr(faddr[0]), .MAddr(maddr[0]), .RAddr(raddr[0]),
      .FWData(fwd[0]), .MWData(mwd[0]), .RWData(rwd[0]),
      .FAck(fack[0]), .MAck(mack[0]), .RAck(rack[0]), .RData(rdata[0]),
      .MemEn(memen[0]), .MemWe(memwe[0]), .MemAddr(memaddr[0]),
      .MemWData(memwdata[0]), .MemRData(memrdata[0]),
      .Busy(busy[0]), .Owner(owner[0])
   );

   mem_port_arbiter #(.AW(16), .DW(16), .LAT(3)) dut3 (
      .CLK(clk), .CtrlRst(rst),
      .FReq(freq[1]), .MReq(mreq[1]), .RReq(rreq[1]),
      .FWe(fwe[1]), .MWe(mwe[1]), .RWe(rwe[1]),
      .FAddr(faddr[1]), .MAddr(maddr[1]), .RAddr(raddr[1]),
      .FWData(fwd[1]), .MWData(mwd[1]), .RWData(rwd[1]),
      .FAck(fack[1]), .MAck(mack[1]), .RAck(rack[1]), .RData(rdata[1]),
      .MemEn(memen[1]), .MemWe(memwe[1]), .MemAddr(memaddr[1]),
      .MemWData(memwdata[1]), .MemRData(memrdata[1]),
      .Busy(busy[1]), .Owner(owner[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory environment: data appears LAT cycles after the strobe, junk otherwise.
   logic [15:0] emem [logic [15:0]];
   logic [15:0] stg [2][8];

   initial begin
      for (int d = 0; d < 2; d++)
         for (int j = 0; j < 8; j++) stg[d][j] = 16'h0BAD;
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (memen[d] && memwe[d]) emem[memaddr[d]] = memwdata[d];
         for (int j = 7; j > 0; j--) stg[d][j] <= stg[d][j-1];
         if (memen[d] && !memwe[d])
            stg[d][0] <= emem.exists(memaddr[d]) ? emem[memaddr[d]] : 16'h0000;
         else
            stg[d][0] <= 16'h0BAD;
      end
   end

   assign memrdata[0] = stg[0][0];
   assign memrdata[1] = stg[1][2];

   // Transaction-level model: mt = cycles since grant (0 = free), ack at LAT+2.
   int          lat_of [2] = '{1, 3};
   int          mt   [2];
   int          mown [2];
   int          mptr [2];
   logic        mwe_m[2];
   logic [15:0] madr [2];
   logic [15:0] mwdt [2];
   logic [15:0] mrd  [2];
   logic [15:0] mmem [logic [15:0]];
   int          pw;

   function automatic int pick_fixed(input logic [2:0] rq);
      for (int i = 0; i < 3; i++) if (rq[i]) return i;
      return -1;
   endfunction

   function automatic int pick_rr(input logic [2:0] rq, input int ptr);
      for (int k = 0; k < 3; k++) if (rq[(ptr + k) % 3]) return (ptr + k) % 3;
      return -1;
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         mt[d] = 0; mown[d] = 3; mptr[d] = 0; mrd[d] = 16'h0;
         mwe_m[d] = 1'b0; madr[d] = 16'h0; mwdt[d] = 16'h0;
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            mt[d] = 0; mown[d] = 3; mptr[d] = 0; mrd[d] = 16'h0;
         end else if (mt[d] == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            pw = pick_rr({rreq[d], mreq[d], freq[d]}, mptr[d]);
`else
            pw = pick_fixed({rreq[d], mreq[d], freq[d]});
`endif
            if (pw >= 0) begin
               mt[d] = 1; mown[d] = pw; mptr[d] = (pw + 1) % 3;
               case (pw)
                  0:       begin mwe_m[d] = fwe[d]; madr[d] = faddr[d]; mwdt[d] = fwd[d]; end
                  1:       begin mwe_m[d] = mwe[d]; madr[d] = maddr[d]; mwdt[d] = mwd[d]; end
                  default: begin mwe_m[d] = rwe[d]; madr[d] = raddr[d]; mwdt[d] = rwd[d]; end
               endcase
            end
         end else if (mt[d] == lat_of[d] + 2) begin
            mt[d] = 0; mown[d] = 3;
         end else begin
            mt[d] = mt[d] + 1;
            if (mt[d] == lat_of[d] + 2) begin
               if (mwe_m[d]) mmem[madr[d]] = mwdt[d];
               else mrd[d] = mmem.exists(madr[d]) ? mmem[madr[d]] : 16'h0000;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d Busy", d),  16'(busy[d]),  16'(mt[d] != 0));
            chk($sformatf("d%0d MemEn", d), 16'(memen[d]), 16'(mt[d] == 1));
            chk($sformatf("d%0d MemWe", d), 16'(memwe[d]), 16'(mt[d] == 1 && mwe_m[d]));
            chk($sformatf("d%0d FAck", d),  16'(fack[d]),  16'(mt[d] == lat_of[d] + 2 && mown[d] == 0));
            chk($sformatf("d%0d MAck", d),  16'(mack[d]),  16'(mt[d] == lat_of[d] + 2 && mown[d] == 1));
            chk($sformatf("d%0d RAck", d),  16'(rack[d]),  16'(mt[d] == lat_of[d] + 2 && mown[d] == 2));
            chk($sformatf("d%0d Owner", d), 16'(owner[d]), (mt[d] == 0) ? 16'd3 : 16'(mown[d]));
            chk($sformatf("d%0d RData", d), rdata[d], mrd[d]);
            if (mt[d] == 1) begin
               chk($sformatf("d%0d MemAddr", d), memaddr[d], madr[d]);
               if (mwe_m[d]) chk($sformatf("d%0d MemWData", d), memwdata[d], mwdt[d]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   int ack_ord [4];
   int ack_cyc [4];
   int nack;
   int own4, own5;
   int exp_ord [4];

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         freq[d] = 0; mreq[d] = 0; rreq[d] = 0;
         fwe[d] = 0; mwe[d] = 0; rwe[d] = 0;
         faddr[d] = 0; maddr[d] = 0; raddr[d] = 0;
         fwd[d] = 0; mwd[d] = 0; rwd[d] = 0;
      end
      emem[16'h0010] = 16'hBEEF; mmem[16'h0010] = 16'hBEEF;
      emem[16'h0020] = 16'hC0DE; mmem[16'h0020] = 16'hC0DE;
      emem[16'h0030] = 16'hF00D; mmem[16'h0030] = 16'hF00D;
      emem[16'h0200] = 16'h5A5A; mmem[16'h0200] = 16'h5A5A;
      @(negedge clk);
      step();
      armed = 1'b1;
      step();
      rst = 1'b0;
      chk("reset Owner", 16'(owner[0]), 16'd3);
      chk("reset Busy", 16'(busy[0]), 16'd0);
      chk("reset RData", rdata[0], 16'h0000);
      chk("reset MemEn", 16'(memen[0]), 16'd0);
      chk("reset MemAddr", memaddr[0], 16'h0000);
      step();

      // Fetch read of 0x0010.
      freq[0] = 1; fwe[0] = 0; faddr[0] = 16'h0010;
      step();
      chk("t1 MemEn c1", 16'(memen[0]), 16'd1);
      chk("t1 MemAddr c1", memaddr[0], 16'h0010);
      chk("t1 Busy c1", 16'(busy[0]), 16'd1);
      chk("t1 Owner c1", 16'(owner[0]), 16'd0);
      step();
      chk("t1 Busy c2", 16'(busy[0]), 16'd1);
      step();
      chk("t1 FAck c3", 16'(fack[0]), 16'd1);
      chk("t1 RData c3", rdata[0], 16'hBEEF);
      chk("t1 Busy c3", 16'(busy[0]), 16'd1);
      freq[0] = 0;
      step();
      chk("t1 Busy c4", 16'(busy[0]), 16'd0);
      chk("t1 Owner c4", 16'(owner[0]), 16'd3);

      // Main-stack write.
      mreq[0] = 1; mwe[0] = 1; maddr[0] = 16'hFF00; mwd[0] = 16'h1234;
      step();
      chk("t2 MemEn c1", 16'(memen[0]), 16'd1);
      chk("t2 MemWe c1", 16'(memwe[0]), 16'd1);
      chk("t2 MemAddr c1", memaddr[0], 16'hFF00);
      chk("t2 MemWData c1", memwdata[0], 16'h1234);
      step();
      step();
      chk("t2 MAck c3", 16'(mack[0]), 16'd1);
      chk("t2 RData kept", rdata[0], 16'hBEEF);
      mreq[0] = 0; mwe[0] = 0;
      step();

      // Three simultaneous reads from a fresh reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      freq[0] = 1; faddr[0] = 16'h0010;
      mreq[0] = 1; maddr[0] = 16'h0020;
      rreq[0] = 1; raddr[0] = 16'h0030;
      nack = 0; own4 = -1; own5 = -1;
      for (int c = 1; c <= 40 && nack < 3; c++) begin
         step();
         if (c == 4) own4 = owner[0];
         if (c == 5) own5 = owner[0];
         if (fack[0]) begin ack_ord[nack] = 0; ack_cyc[nack] = c; nack++; freq[0] = 0; end
         if (mack[0]) begin ack_ord[nack] = 1; ack_cyc[nack] = c; nack++; mreq[0] = 0; end
         if (rack[0]) begin ack_ord[nack] = 2; ack_cyc[nack] = c; nack++; rreq[0] = 0; end
      end
      freq[0] = 0; mreq[0] = 0; rreq[0] = 0;
      chk("t3 ack count", 16'(nack), 16'd3);
      if (nack == 3) begin
         chk("t3 order 0", 16'(ack_ord[0]), 16'd0);
         chk("t3 order 1", 16'(ack_ord[1]), 16'd1);
         chk("t3 order 2", 16'(ack_ord[2]), 16'd2);
         chk("t3 cycle 0", 16'(ack_cyc[0]), 16'd3);
         chk("t3 cycle 1", 16'(ack_cyc[1]), 16'd7);
         chk("t3 cycle 2", 16'(ack_cyc[2]), 16'd11);
      end
      chk("t3 Owner c4", 16'(own4), 16'd3);
      chk("t3 Owner c5", 16'(own5), 16'd1);
      step();

      // All three held high continuously.
      freq[0] = 1; mreq[0] = 1; rreq[0] = 1;
      nack = 0;
      for (int c = 1; c <= 60 && nack < 4; c++) begin
         step();
         if (fack[0]) begin ack_ord[nack] = 0; nack++; end
         if (mack[0]) begin ack_ord[nack] = 1; nack++; end
         if (rack[0]) begin ack_ord[nack] = 2; nack++; end
      end
      freq[0] = 0; mreq[0] = 0; rreq[0] = 0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_ord = '{0, 1, 2, 0};
`else
      exp_ord = '{0, 0, 0, 0};
`endif
      chk("t4 ack count", 16'(nack), 16'd4);
      if (nack == 4)
         for (int i = 0; i < 4; i++)
            chk($sformatf("t4 order %0d", i), 16'(ack_ord[i]), 16'(exp_ord[i]));
      step();
      step();

      // LAT=3 return-stack read.
      rreq[1] = 1; rwe[1] = 0; raddr[1] = 16'h0200;
      step();
      chk("t5 MemEn c1", 16'(memen[1]), 16'd1);
      step();
      step();
      step();
      chk("t5 MemRData c4", memrdata[1], 16'h5A5A);
      chk("t5 RData c4", rdata[1], 16'h0000);
      step();
      chk("t5 RAck c5", 16'(rack[1]), 16'd1);
      chk("t5 RData c5", rdata[1], 16'h5A5A);
      rreq[1] = 0;
      step();

      // Reset in the middle of a fetch.
      freq[0] = 1; faddr[0] = 16'h0020;
      step();
      step();
      rst = 1'b1;
      step();
      chk("t6 FAck c3", 16'(fack[0]), 16'd0);
      chk("t6 MemEn c3", 16'(memen[0]), 16'd0);
      chk("t6 Owner c3", 16'(owner[0]), 16'd3);
      chk("t6 Busy c3", 16'(busy[0]), 16'd0);
      chk("t6 RData c3", rdata[0], 16'h0000);
      rst = 1'b0;
      faddr[0] = 16'h0010;
      step();
      step();
      step();
      chk("t6 FAck after", 16'(fack[0]), 16'd1);
      chk("t6 RData after", rdata[0], 16'hBEEF);
      freq[0] = 0;
      step();

      // Read back the earlier write.
      mreq[0] = 1; mwe[0] = 0; maddr[0] = 16'hFF00;
      step();
      step();
      step();
      chk("rb MAck", 16'(mack[0]), 16'd1);
      chk("rb RData", rdata[0], 16'h1234);
      mreq[0] = 0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
